sram_controller: RTL and testbench

Responder end of the shared SRAM bus used by the decoder's score-processing blocks (normaliser and similar masters). It accepts level-held read/write requests on the bus and drives the external asynchronous 1M x 16 SRAM with a parameterised number of wait states. It returns each result with a single-cycle `sram_ready` pulse. It is the only responder on the bus.

---
 rtl/sram_controller_if.sv | 20 ++
 rtl/sram_controller.sv | 129 ++++++++++++
 tb/tb_sram_controller.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_controller_if.sv
// Shared SRAM bus between the score-processing masters and the SRAM controller.
// Masters tri-state every line they drive while they are idle.
interface sram_controller_if;
  logic [20:0] data_addr;
  logic        read_data;
  logic        write_data;
  logic [15:0] data_out;
  logic [15:0] data_in;
  logic        sram_ready;

  modport master (
    output data_addr, read_data, write_data, data_out,
    input  data_in, sram_ready
  );

  modport slave (
    input  data_addr, read_data, write_data, data_out,
    output data_in, sram_ready
  );
endinterface

// File: rtl/sram_controller.sv
// Responder for the shared SRAM bus. It turns level-held read/write requests
// into timed accesses on an external asynchronous 1M x 16 SRAM. Each result
// is returned with a one-cycle sram_ready pulse.
module sram_controller #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  sram_controller_if.slave   bus,
  output logic [19:0]        ext_addr,
  inout  wire  [15:0]        ext_data,
  output logic               ext_ce_n,
  output logic               ext_oe_n,
  output logic               ext_we_n
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] COUNT_LOAD = CW'(WAIT_CYCLES - 1);

  generate
    if (WAIT_CYCLES < 1) begin : g_bad_wait
      $error("sram_controller: WAIT_CYCLES must be at least 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WSETUP,
    WPULSE,
    WHOLD,
    DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [15:0]   wdata_q;
  logic [15:0]   rdata_q;
  logic          drive_q;
  logic          ready_q;
  logic          addr_lsb_unused;

  // Byte address bit 0 has no meaning for a 16-bit word SRAM.
  assign addr_lsb_unused = bus.data_addr[0];

  // The data bus is driven only while a write owns it.
  assign ext_data       = drive_q ? wdata_q : 16'hzzzz;
  assign bus.data_in    = rdata_q;
  assign bus.sram_ready = ready_q;

  // The access sequencer. Strobes, bus drive and ready are registered here, so they are glitch-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      ext_addr <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      drive_q  <= 1'b0;
      ready_q  <= 1'b0;
      ext_ce_n <= 1'b1;
      ext_oe_n <= 1'b1;
      ext_we_n <= 1'b1;
    end else begin
      ready_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.write_data == 1'b1) begin
            ext_addr <= bus.data_addr[20:1];
            wdata_q  <= bus.data_out;
            drive_q  <= 1'b1;
            ext_ce_n <= 1'b0;
            ext_oe_n <= 1'b1;
            ext_we_n <= 1'b1;
            state    <= WSETUP;
          end else if (bus.read_data == 1'b1) begin
            ext_addr <= bus.data_addr[20:1];
            ext_ce_n <= 1'b0;
            ext_oe_n <= 1'b0;
            ext_we_n <= 1'b1;
            count    <= COUNT_LOAD;
            state    <= RD;
          end
        end
        RD: begin
          if (count == '0) begin
            rdata_q  <= ext_data;
            ext_ce_n <= 1'b1;
            ext_oe_n <= 1'b1;
            ready_q  <= 1'b1;
            state    <= DONE;
          end else begin
            count <= count - 1'b1;
          end
        end
        WSETUP: begin
          ext_we_n <= 1'b0;
          count    <= COUNT_LOAD;
          state    <= WPULSE;
        end
        WPULSE: begin
          if (count == '0) begin
            ext_we_n <= 1'b1;
            state    <= WHOLD;
          end else begin
            count <= count - 1'b1;
          end
        end
        WHOLD: begin
          ext_ce_n <= 1'b1;
          drive_q  <= 1'b0;
          ready_q  <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          ext_ce_n <= 1'b1;
          ext_oe_n <= 1'b1;
          ext_we_n <= 1'b1;
          drive_q  <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller with WAIT_CYCLES=2. An asynchronous SRAM model
// sits on the external bus. Directed accesses push their expected responses
// into a scoreboard queue, and a monitor pops and checks them on each ready
// pulse.
module tb_sram_controller;
  localparam int W = 2;

  logic        clk = 1'b0;
  logic        reset;
  wire  [15:0] ext_data;
  logic [19:0] ext_addr;
  logic        ext_ce_n;
  logic        ext_oe_n;
  logic        ext_we_n;
  logic        probe_en;
  logic [15:0] mem [0:63];
  int          cyc = 0;
  int          tests = 0;
  int          failed = 0;
  bit          prev_ready = 1'b0;

  typedef struct {
    logic [15:0] data_in;
    int          due;
    string       name;
  } exp_t;
  exp_t sb_q[$];

  sram_controller_if bus();

  sram_controller #(.WAIT_CYCLES(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .ext_addr (ext_addr),
    .ext_data (ext_data),
    .ext_ce_n (ext_ce_n),
    .ext_oe_n (ext_oe_n),
    .ext_we_n (ext_we_n)
  );

  // The system clock has a 10-unit period.
  always #5 clk = ~clk;

  // A cycle counter lets the scoreboard check latency.
  always @(posedge clk) cyc <= cyc + 1;

  // The SRAM model drives reads while CE and OE are low.
  // Otherwise a probe pattern can sit on the bus to expose any stray drive.
  assign ext_data = (ext_ce_n == 1'b0 && ext_oe_n == 1'b0) ? mem[ext_addr[5:0]]
                  : (probe_en ? 16'h5A5A : 16'hzzzz);

  // The SRAM model stores data while CE and WE are low, and is preloaded while reset is held.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= 16'h0000;
      mem[5] <= 16'h1234;
      mem[0] <= 16'd100;
    end else if (ext_ce_n == 1'b0 && ext_we_n == 1'b0) begin
      mem[ext_addr[5:0]] <= ext_data;
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_lines();
    bus.read_data  = 1'bz;
    bus.write_data = 1'bz;
    bus.data_addr  = 'z;
    bus.data_out   = 'z;
  endtask

  // Drive a request and queue its expected response.
  // lead=1 means the request is driven in the DONE cycle of the previous access.
  task automatic apply_stimulus(input bit rd, input bit wr, input logic [20:0] addr,
                                input logic [15:0] wd, input logic [15:0] exp_data_in,
                                input int lead, input string name);
    exp_t e;
    bus.data_addr  = addr;
    bus.data_out   = wd;
    bus.read_data  = rd;
    bus.write_data = wr;
    e.data_in = exp_data_in;
    e.due     = cyc + lead + (wr ? W + 3 : W + 1);
    e.name    = name;
    sb_q.push_back(e);
  endtask

  // Follow an access cycle by cycle from cycle 1 until the ready pulse.
  task automatic track_access(input bit wr, input logic [19:0] waddr,
                              input logic [15:0] wd, input string name);
    int k = 0;
    logic [2:0] exp_strobe;
    do begin
      step();
      k++;
      if (wr) begin
        if (k == 1 || k == W + 2) exp_strobe = 3'b011;
        else if (k <= W + 1)      exp_strobe = 3'b010;
        else                      exp_strobe = 3'b111;
        if (k <= W + 2) begin
          check_output($sformatf("%s ext_addr c%0d", name, k), ext_addr, waddr);
          check_output($sformatf("%s ext_data c%0d", name, k), ext_data, wd);
        end
      end else begin
        exp_strobe = (k <= W) ? 3'b001 : 3'b111;
        if (k <= W) check_output($sformatf("%s ext_addr c%0d", name, k), ext_addr, waddr);
      end
      check_output($sformatf("%s ce/oe/we c%0d", name, k),
                   {ext_ce_n, ext_oe_n, ext_we_n}, exp_strobe);
    end while (bus.sram_ready !== 1'b1 && k < 12);
    if (bus.sram_ready !== 1'b1) begin
      tests++;
      failed++;
      $display("[TB] FAIL %s timeout: got no sram_ready in %0d cycles, expected one", name, k);
    end
  endtask

  // The scoreboard monitor checks every ready pulse against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.sram_ready === 1'b1) begin
        check_output("ready single-cycle", {31'd0, prev_ready}, 32'd0);
        if (sb_q.size() == 0) begin
          tests++;
          failed++;
          $display("[TB] FAIL unexpected ready: got pulse at cycle %0d, expected none", cyc);
        end else begin
          e = sb_q.pop_front();
          check_output({e.name, " latency"}, cyc, e.due);
          check_output({e.name, " data_in"}, bus.data_in, e.data_in);
        end
      end
      prev_ready = (bus.sram_ready === 1'b1);
    end
  end

  // The watchdog stops the run if the stimulus ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of stimulus, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // The directed stimulus sequence.
  initial begin
    logic [15:0] res;
    probe_en = 1'b0;
    idle_lines();
    reset = 1'b1;
    repeat (3) step();
    check_output("reset sram_ready", bus.sram_ready, 0);
    check_output("reset data_in", bus.data_in, 0);
    check_output("reset strobes", {ext_ce_n, ext_oe_n, ext_we_n}, 3'b111);
    check_output("reset ext_addr", ext_addr, 0);
    reset = 1'b0;

    // Request lines float at Z, then at X. No access may start.
    probe_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) begin
        bus.read_data  = 1'bx;
        bus.write_data = 1'bx;
      end
      step();
      check_output($sformatf("idle strobes %0d", i), {ext_ce_n, ext_oe_n, ext_we_n}, 3'b111);
      if (i % 5 == 0) check_output($sformatf("idle ext_data %0d", i), ext_data, 16'h5A5A);
    end
    probe_en = 1'b0;
    idle_lines();
    step();

    // Read byte address 10, which is word 5 and holds 0x1234.
    apply_stimulus(1'b1, 1'b0, 21'd10, 16'h0000, 16'h1234, 0, "read w5");
    track_access(1'b0, 20'd5, 16'h0000, "read w5");
    idle_lines();
    step();

    // Write -3 to byte address 6, which is word 3. data_in keeps the last read.
    apply_stimulus(1'b0, 1'b1, 21'd6, 16'hFFFD, 16'h1234, 0, "write w3");
    track_access(1'b1, 20'd3, 16'hFFFD, "write w3");
    idle_lines();
    step();
    check_output("sram word 3", mem[3], 16'hFFFD);

    // Read word 0, then write 250 minus the result back to word 0 in the next cycle.
    apply_stimulus(1'b1, 1'b0, 21'd0, 16'h0000, 16'd100, 0, "b2b read");
    track_access(1'b0, 20'd0, 16'h0000, "b2b read");
    res = 16'd250 - bus.data_in;
    apply_stimulus(1'b0, 1'b1, 21'd0, res, 16'd100, 1, "b2b write");
    step();
    track_access(1'b1, 20'd0, 16'd150, "b2b write");
    idle_lines();
    step();
    check_output("sram word 0", mem[0], 16'd150);
    check_output("data_in after write", bus.data_in, 16'd100);

    // With both requests at 1, the write path wins and OE never drops.
    apply_stimulus(1'b1, 1'b1, 21'd8, 16'h0BEE, 16'd100, 0, "rd+wr");
    track_access(1'b1, 20'd4, 16'h0BEE, "rd+wr");
    idle_lines();
    step();
    check_output("sram word 4", mem[4], 16'h0BEE);

    // Reset lands in the second WPULSE cycle of a write. It takes effect at once.
    bus.data_addr  = 21'd14;
    bus.data_out   = 16'h7777;
    bus.write_data = 1'b1;
    bus.read_data  = 1'b0;
    repeat (3) step();
    check_output("pre-reset we_n", ext_we_n, 1'b0);
    reset    = 1'b1;
    probe_en = 1'b1;
    #1;
    check_output("mid-write reset strobes", {ext_ce_n, ext_oe_n, ext_we_n}, 3'b111);
    check_output("mid-write reset sram_ready", bus.sram_ready, 0);
    check_output("mid-write reset data_in", bus.data_in, 0);
    check_output("mid-write reset ext_data", ext_data, 16'h5A5A);
    idle_lines();
    step();
    reset    = 1'b0;
    probe_en = 1'b0;
    step();

    // After reset, a read completes with normal latency.
    apply_stimulus(1'b1, 1'b0, 21'd10, 16'h0000, 16'h1234, 0, "post-reset read");
    track_access(1'b0, 20'd5, 16'h0000, "post-reset read");
    idle_lines();
    repeat (3) step();

    check_output("scoreboard drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
